hps_ext_bus_slave: RTL and testbench

//  Slave end of the HPS external-bus (Avalon conduit) link. Decodes HPS read/write requests

---
 rtl/hps_ext_bus_slave.sv | 130 +++++++++++++
 tb/tb_hps_ext_bus_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_ext_bus_slave.sv
// HPS external-bus (Avalon conduit) slave: turns held read/write requests into single-word
// accesses on the sc_computer debug memory port. Optional mem_ready timeout: BRIDGE_TIMEOUT_EN.
module hps_ext_bus_slave #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] avalon_address,
    input  logic [3:0]        avalon_byte_enable,
    input  logic              avalon_read,
    input  logic              avalon_write,
    input  logic [31:0]       avalon_write_data,
    output logic              avalon_acknowledge,
    output logic [31:0]       avalon_read_data,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_busy,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {StIdle, StAccess, StAck, StRelease} state_e;

    state_e              state_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                re_q;
    logic                we_q;
    logic                ack_q;
    logic [7:0]          err_q;

    // Word-aligned accesses only; the byte offset carries no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^avalon_address[1:0];

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_q;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYC);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (avalon_read && avalon_write) begin
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                        rdata_q <= ERR_DATA;
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end else if (avalon_read || avalon_write) begin
                        addr_q  <= avalon_address[ADDR_W-1:2];
                        be_q    <= avalon_read ? 4'hF : avalon_byte_enable;
                        wdata_q <= avalon_write_data;
                        re_q    <= avalon_read;
                        we_q    <= avalon_write;
`ifdef BRIDGE_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (mem_ready) begin
                        if (re_q) rdata_q <= mem_rdata;
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (wait_q == TimeoutLast) begin
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                        rdata_q <= ERR_DATA;
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
`endif
                end
                StAck: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // Hold here until the master drops its request so it is not re-issued.
                    if (!avalon_read && !avalon_write) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign avalon_acknowledge = ack_q;
    assign avalon_read_data   = rdata_q;
    assign mem_addr           = addr_q;
    assign mem_be             = be_q;
    assign mem_wdata          = wdata_q;
    assign mem_re             = re_q;
    assign mem_we             = we_q;
    assign bus_busy           = (state_q != StIdle);
    assign err_count          = err_q;

endmodule

// File: tb/tb_hps_ext_bus_slave.sv
// Directed, table-driven bench for hps_ext_bus_slave with a simple reactive memory model.
module tb_hps_ext_bus_slave;

    logic        clock;
    logic        resetn;
    logic [23:0] avalon_address;
    logic [3:0]  avalon_byte_enable;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_write_data;
    logic        avalon_acknowledge;
    logic [31:0] avalon_read_data;
    logic [21:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_busy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    hps_ext_bus_slave #(
        .ADDR_W      (24),
        .TIMEOUT_CYC (8),
        .ERR_DATA    (32'hDEADBEEF)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .avalon_address     (avalon_address),
        .avalon_byte_enable (avalon_byte_enable),
        .avalon_read        (avalon_read),
        .avalon_write       (avalon_write),
        .avalon_write_data  (avalon_write_data),
        .avalon_acknowledge (avalon_acknowledge),
        .avalon_read_data   (avalon_read_data),
        .mem_addr           (mem_addr),
        .mem_be             (mem_be),
        .mem_wdata          (mem_wdata),
        .mem_re             (mem_re),
        .mem_we             (mem_we),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .bus_busy           (bus_busy),
        .err_count          (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          delay;
        int          hold;
        int          exp_strobes;
        int          exp_ack_at;
        logic [21:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request just after a negedge and watches it to completion (or limit cycles).
    // delay = strobe cycle on which mem_ready rises (0 = never).
    task automatic run_txn(input logic rd, input logic wr, input logic [23:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] md,
                           input int delay, input int hold, input int limit,
                           output int strobes, output int acks, output int ack_at,
                           output logic saw_re, output logic saw_we, output logic [21:0] a,
                           output logic [3:0] b, output logic [31:0] w,
                           output logic [31:0] ack_data);
        int  cyc;
        bit  done;
        strobes = 0; acks = 0; ack_at = 0; saw_re = 0; saw_we = 0;
        a = '0; b = '0; w = '0; ack_data = '0;
        cyc = 0; done = 0;
        avalon_read = rd; avalon_write = wr; avalon_address = addr;
        avalon_byte_enable = be; avalon_write_data = wd;
        mem_ready = 1'b0; mem_rdata = md;
        while (!done && cyc < limit) begin
            @(negedge clock);
            cyc++;
            if (mem_re || mem_we) begin
                strobes++;
                saw_re = saw_re | mem_re;
                saw_we = saw_we | mem_we;
                a = mem_addr; b = mem_be; w = mem_wdata;
                mem_ready = (delay != 0) && (strobes >= delay);
            end else begin
                mem_ready = 1'b0;
            end
            if (avalon_acknowledge) begin
                acks++;
                if (acks == 1) begin
                    ack_at = cyc;
                    ack_data = avalon_read_data;
                end
            end
            if (acks > 0 && cyc >= ack_at + hold) begin
                avalon_read = 1'b0;
                avalon_write = 1'b0;
            end
            if (acks > 0 && cyc > ack_at + hold && !bus_busy) done = 1;
        end
    endtask

    int          s, k, at;
    logic        sre, swe;
    logic [21:0] ra;
    logic [3:0]  rb;
    logic [31:0] rw, rd_ack;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 24'h000010, 4'b0011, 32'h12345678, 32'h0, 2, 0, 2, 3,
                    22'h4, 4'b0011, 32'h0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 24'h000020, 4'h0, 32'h0, 32'hCAFEF00D, 1, 5, 1, 2,
                    22'h8, 4'hF, 32'hCAFEF00D, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 24'hFFFFFF, 4'b1000, 32'hA5A5A5A5, 32'h0, 3, 0, 3, 4,
                    22'h3FFFFF, 4'b1000, 32'hCAFEF00D, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 24'h000123, 4'b0101, 32'h0, 32'h01234567, 4, 1, 4, 5,
                    22'h48, 4'hF, 32'h01234567, 8'd0};
        vecs[4] = '{1'b1, 1'b1, 24'h000200, 4'hF, 32'h0, 32'h0, 1, 0, 0, 1,
                    22'h0, 4'h0, 32'hDEADBEEF, 8'd1};
        vecs[5] = '{1'b0, 1'b1, 24'h000004, 4'hF, 32'h0, 32'h0, 1, 2, 1, 2,
                    22'h1, 4'hF, 32'hDEADBEEF, 8'd1};
        vecs[6] = '{1'b1, 1'b0, 24'h000020, 4'h0, 32'h0, 32'h0, 1, 0, 1, 2,
                    22'h8, 4'hF, 32'h0, 8'd1};

        resetn = 1'b0;
        avalon_address = '0; avalon_byte_enable = '0; avalon_read = 1'b0;
        avalon_write = 1'b0; avalon_write_data = '0; mem_rdata = '0; mem_ready = 1'b0;
        #12;
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ack", 32'(avalon_acknowledge), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_rdata", avalon_read_data, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                    vecs[i].mdata, vecs[i].delay, vecs[i].hold, 60,
                    s, k, at, sre, swe, ra, rb, rw, rd_ack);
            check($sformatf("v%0d_strobes", i), 32'(s), 32'(vecs[i].exp_strobes));
            check($sformatf("v%0d_acks", i), 32'(k), 32'd1);
            check($sformatf("v%0d_ack_at", i), 32'(at), 32'(vecs[i].exp_ack_at));
            check($sformatf("v%0d_rdata_ack", i), rd_ack, vecs[i].exp_rdata);
            check($sformatf("v%0d_rdata_held", i), avalon_read_data, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
            if (vecs[i].exp_strobes > 0) begin
                check($sformatf("v%0d_addr", i), 32'(ra), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_be", i), 32'(rb), 32'(vecs[i].exp_be));
                check($sformatf("v%0d_re", i), 32'(sre), 32'(vecs[i].rd));
                check($sformatf("v%0d_we", i), 32'(swe), 32'(vecs[i].wr));
                if (vecs[i].wr) check($sformatf("v%0d_wdata", i), rw, vecs[i].wdata);
            end else begin
                check($sformatf("v%0d_no_strobe", i), 32'(sre | swe), 32'd0);
            end
        end

        // Drive the fault counter into saturation.
        for (int i = 0; i < 253; i++) begin
            run_txn(1'b1, 1'b1, 24'h0, 4'h0, 32'h0, 32'h0, 1, 0, 20,
                    s, k, at, sre, swe, ra, rb, rw, rd_ack);
        end
        check("err_254", 32'(err_count), 32'd254);
        run_txn(1'b1, 1'b1, 24'h0, 4'h0, 32'h0, 32'h0, 1, 0, 20,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("err_255", 32'(err_count), 32'd255);
        run_txn(1'b1, 1'b1, 24'h0, 4'h0, 32'h0, 32'h0, 1, 0, 20,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("err_sat", 32'(err_count), 32'd255);
        check("err_sat_ack", 32'(k), 32'd1);

`ifdef BRIDGE_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 24'h000030, 4'h0, 32'h0, 32'h11111111, 0, 0, 60,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("to_strobes", 32'(s), 32'd8);
        check("to_acks", 32'(k), 32'd1);
        check("to_ack_at", 32'(at), 32'd9);
        check("to_rdata", rd_ack, 32'hDEADBEEF);
        check("to_err_sat", 32'(err_count), 32'd255);
`else
        run_txn(1'b1, 1'b0, 24'h000030, 4'h0, 32'h0, 32'h11111111, 0, 0, 1000,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("nto_acks", 32'(k), 32'd0);
        check("nto_strobes", 32'(s), 32'd1000);
        check("nto_busy", 32'(bus_busy), 32'd1);
`endif

        // Abort an access in flight with reset.
        run_txn(1'b1, 1'b0, 24'h000030, 4'h0, 32'h0, 32'h0, 0, 0, 3,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("pre_rst_strobes", 32'(s), 32'd3);
        check("pre_rst_acks", 32'(k), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_re", 32'(mem_re), 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_busy", 32'(bus_busy), 32'd0);
        check("mid_rst_ack", 32'(avalon_acknowledge), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        @(negedge clock);
        check("in_rst_ack", 32'(avalon_acknowledge), 32'd0);
        @(negedge clock);
        avalon_read = 1'b0;
        mem_ready = 1'b0;
        resetn = 1'b1;
        run_txn(1'b1, 1'b0, 24'h000040, 4'h0, 32'h0, 32'h5A5A5A5A, 2, 0, 60,
                s, k, at, sre, swe, ra, rb, rw, rd_ack);
        check("post_rst_strobes", 32'(s), 32'd2);
        check("post_rst_acks", 32'(k), 32'd1);
        check("post_rst_ack_at", 32'(at), 32'd3);
        check("post_rst_addr", 32'(ra), 32'h10);
        check("post_rst_rdata", avalon_read_data, 32'h5A5A5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
